// File: rtl/l2_assoc_if.sv
// l2_assoc_if: L1 request port and memory port of the l2_assoc cache.
// master = L1/memory side (bench), slave = cache side.
interface l2_assoc_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output addr, read, write, wdata, mem_rdata, mem_ready,
    input  rdata, ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  addr, read, write, wdata, mem_rdata, mem_ready,
    output rdata, ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_assoc.sv
// l2_assoc: WAYS-way set-associative, write-back, write-allocate line cache with LRU ages.
// Define L2_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counter outputs.
module l2_assoc #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 28
) (
  input  logic        clk,
  input  logic        reset,
`ifdef L2_PERF_CNT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  l2_assoc_if.slave   bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t r_state, w_state_nxt;

  logic              r_valid [SETS][WAYS];
  logic              r_dirty [SETS][WAYS];
  logic [WAY_W-1:0]  r_age   [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [LINE_W-1:0] r_data  [SETS][WAYS];

  logic [ADDR_W-1:0] r_addr, r_mem_addr, w_mem_addr_nxt;
  logic [LINE_W-1:0] r_wdata, r_rdata, r_mem_wdata, w_rdata_nxt, w_mem_wdata_nxt;
  logic              r_is_read, r_abort, r_done;
  logic              r_ready, r_mem_read, r_mem_write;
  logic              w_ready_nxt, w_mem_read_nxt, w_mem_write_nxt;
  logic [WAY_W-1:0]  r_victim, w_hit_way, w_inv_way, w_lru_way, w_vict, w_upd_way;
  logic              w_hit, w_has_inv, w_req, w_start, w_hit_upd, w_miss, w_fill, w_lru_upd;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;

  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_tag     = r_addr[ADDR_W-1:IDX_W];
  assign w_req     = bus.read | bus.write;
  assign w_lru_upd = w_hit_upd | w_fill;
  assign w_upd_way = w_fill ? r_victim : w_hit_way;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_lru_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w] && !w_has_inv) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
    end
    w_vict = w_has_inv ? w_inv_way : w_lru_way;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ready_nxt     = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_start         = 1'b0;
    w_hit_upd       = 1'b0;
    w_miss          = 1'b0;
    w_fill          = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A held request that already got its ready pulse is not restarted.
        if (w_req && !(r_done && (bus.addr == r_addr))) begin
          w_start     = 1'b1;
          w_state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (r_abort) begin
          w_state_nxt = IDLE;
        end else if (w_hit) begin
          w_hit_upd   = 1'b1;
          w_ready_nxt = 1'b1;
          if (r_is_read) w_rdata_nxt = r_data[w_idx][w_hit_way];
          w_state_nxt = IDLE;
        end else begin
          w_miss = 1'b1;
          if (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) begin
            w_state_nxt     = WRITEBACK;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = {r_tag[w_idx][w_vict], w_idx};
            w_mem_wdata_nxt = r_data[w_idx][w_vict];
          end else begin
            w_state_nxt    = ALLOCATE;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = r_addr;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready) begin
          w_state_nxt     = ALLOCATE;
          w_mem_write_nxt = 1'b0;
          w_mem_read_nxt  = 1'b1;
          w_mem_addr_nxt  = r_addr;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          w_state_nxt    = COMPARE;
          w_mem_read_nxt = 1'b0;
          w_fill         = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      r_wdata     <= '0;
      r_abort     <= 1'b0;
      r_done      <= 1'b0;
      r_victim    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= w_ready_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_start) begin
        r_addr    <= bus.addr;
        r_is_read <= bus.read;
        r_wdata   <= bus.wdata;
      end
      if (w_miss) r_victim <= w_vict;
      if (w_start) r_abort <= 1'b0;
      else if (((r_state == WRITEBACK) || (r_state == ALLOCATE)) && !w_req) r_abort <= 1'b1;
      if (w_hit_upd) r_done <= 1'b1;
      else if ((r_state == IDLE) && (!w_req || (bus.addr != r_addr))) r_done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_age[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (w_lru_upd) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (r_age[w_idx][w] < r_age[w_idx][w_upd_way]) r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
        r_age[w_idx][w_upd_way] <= '0;
      end
      if (w_fill) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end else if (w_hit_upd && !r_is_read) begin
        r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx][r_victim] <= bus.mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end else if (w_hit_upd && !r_is_read) begin
      r_data[w_idx][w_hit_way] <= r_wdata;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic        r_postfill;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_postfill <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_start) r_postfill <= 1'b0;
      else if (w_fill) r_postfill <= 1'b1;
      if (w_hit_upd && !r_postfill) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

  assign bus.ready     = r_ready;
  assign bus.rdata     = r_rdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_l2_assoc.sv
// tb_l2_assoc: directed stimulus with a queue scoreboard of expected ready/memory events.
module tb_l2_assoc;
  localparam int K_RD  = 0;
  localparam int K_WR  = 1;
  localparam int K_MRD = 2;
  localparam int K_MWR = 3;

  typedef struct {
    int           kind;
    logic [27:0]  addr;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mem_lat = 2;
  exp_t q[$];
  logic [127:0] mem [logic [27:0]];
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l2_assoc_if #(.ADDR_W(28), .LINE_W(128)) bus ();

  l2_assoc #(.WAYS(4), .SETS(16), .LINE_W(128), .ADDR_W(28)) dut (
    .clk      (clk),
    .reset    (rst_n),
`ifdef L2_PERF_CNT_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [27:0] a);
    return {4{4'hB, a}};
  endfunction

  function automatic logic [127:0] memval(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [27:0] a, input logic [127:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [27:0] a, input logic [127:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h", kind, a, d);
      return;
    end
    e = q.pop_front();
    if ((kind == K_RD) && ((e.kind == K_RD) || (e.kind == K_WR))) begin
      if ((e.kind == K_RD) && (d !== e.data)) begin
        errors++;
        $display("FAIL rdata actual=%h required=%h", d, e.data);
      end
    end else if (kind != e.kind) begin
      errors++;
      $display("FAIL event_kind actual=%0d required=%0d addr=%h", kind, e.kind, a);
    end else if ((a !== e.addr) || ((kind == K_MWR) && (d !== e.data))) begin
      errors++;
      $display("FAIL mem_req kind=%0d actual=%h/%h required=%h/%h", kind, a, d, e.addr, e.data);
    end
  endtask

  // Monitor: every ready pulse and every rising memory request is matched against the queue.
  initial begin
    logic pr, pw;
    pr = 1'b0;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr = 1'b0;
        pw = 1'b0;
      end else begin
        if ((bus.mem_read && !pr) || (bus.mem_write && !pw))
          chk("mem_exclusive", {127'd0, bus.mem_read & bus.mem_write}, 128'd0);
        if (bus.mem_write && !pw) observe(K_MWR, bus.mem_addr, bus.mem_wdata);
        if (bus.mem_read && !pr) observe(K_MRD, bus.mem_addr, '0);
        if (bus.ready) observe(K_RD, '0, bus.rdata);
        pr = bus.mem_read;
        pw = bus.mem_write;
      end
    end
  end

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.mem_read || bus.mem_write)) begin
        repeat (mem_lat) @(negedge clk);
        if (rst_n && (bus.mem_read || bus.mem_write)) begin
          if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = memval(bus.mem_addr);
          bus.mem_ready = 1'b1;
          @(negedge clk);
          bus.mem_ready = 1'b0;
        end
      end
    end
  end

  task automatic req(input logic [27:0] a, input logic rd, input logic wr,
                     input logic [127:0] wd, output int lat);
    bus.addr  = a;
    bus.read  = rd;
    bus.write = wr;
    bus.wdata = wd;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.ready) break;
      if (lat >= 300) begin
        lat = -1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout addr=%h actual=none required=ready", a);
    end
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_mread();
    int n;
    n = 0;
    while (!bus.mem_read && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_read) begin
      checks++;
      errors++;
      $display("FAIL mem_read_timeout actual=0 required=1");
    end
  endtask

  task automatic rd_miss(input logic [27:0] a, input logic [127:0] d);
    int lat;
    push(K_MRD, a, '0);
    push(K_RD, '0, d);
    req(a, 1'b1, 1'b0, '0, lat);
  endtask

  task automatic rd_hit(input logic [27:0] a, input logic [127:0] d);
    int lat;
    push(K_RD, '0, d);
    req(a, 1'b1, 1'b0, '0, lat);
    chk("hit_latency", 128'(lat), 128'd2);
  endtask

  initial begin
    logic [127:0] w1;
    int lat;
    w1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.addr  = '0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.wdata = '0;
    mem[28'h10] = {16{8'hA5}};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {127'd0, bus.ready}, 128'd0);
    chk("rst_mem_read", {127'd0, bus.mem_read}, 128'd0);
    chk("rst_mem_write", {127'd0, bus.mem_write}, 128'd0);
    chk("rst_rdata", bus.rdata, 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
`ifdef L2_PERF_CNT_EN
    chk("rst_hit_cnt", 128'(hit_cnt), 128'd0);
    chk("rst_miss_cnt", 128'(miss_cnt), 128'd0);
`endif

    // First read fills, re-read hits without memory traffic.
    rd_miss(28'h10, {16{8'hA5}});
    rd_hit(28'h10, {16{8'hA5}});

    // Set 0: tags 1..4 resident, touch tag 1, tag 5 evicts tag 2.
    rd_miss(28'h20, pat(28'h20));
    rd_miss(28'h30, pat(28'h30));
    rd_miss(28'h40, pat(28'h40));
    rd_hit(28'h10, {16{8'hA5}});
    rd_miss(28'h50, pat(28'h50));
    rd_hit(28'h10, {16{8'hA5}});
    rd_miss(28'h20, pat(28'h20));

    // Set 3: dirty line written back before the fifth tag's fill.
    push(K_MRD, 28'h23, '0);
    push(K_WR, '0, '0);
    req(28'h23, 1'b0, 1'b1, w1, lat);
    rd_miss(28'h13, pat(28'h13));
    rd_miss(28'h33, pat(28'h33));
    rd_miss(28'h43, pat(28'h43));
    push(K_MWR, 28'h23, w1);
    rd_miss(28'h53, pat(28'h53));
    rd_miss(28'h23, w1);

    // read+write together behaves as a read; the line stays clean.
    push(K_RD, '0, pat(28'h33));
    req(28'h33, 1'b1, 1'b1, {128{1'b1}}, lat);
    chk("rdwr_latency", 128'(lat), 128'd2);
    rd_hit(28'h33, pat(28'h33));
    rd_miss(28'h63, pat(28'h63));
    rd_miss(28'h73, pat(28'h73));
    rd_miss(28'h83, pat(28'h83));
    rd_miss(28'h93, pat(28'h93));
    rd_miss(28'h33, pat(28'h33));

    // Request dropped mid-miss: fill completes silently, line then hits.
    push(K_MRD, 28'hA0, '0);
    bus.addr = 28'hA0;
    bus.read = 1'b1;
    wait_mread();
    @(negedge clk);
    bus.read = 1'b0;
    repeat (10) @(negedge clk);
    rd_hit(28'hA0, pat(28'hA0));

    // Reset during an outstanding fill.
    mem_lat = 30;
    push(K_MRD, 28'hB0, '0);
    bus.addr = 28'hB0;
    bus.read = 1'b1;
    wait_mread();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_read", {127'd0, bus.mem_read}, 128'd0);
    chk("arst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("arst_ready", {127'd0, bus.ready}, 128'd0);
    bus.read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    mem_lat = 2;

    // 3 misses and 5 first-evaluation hits since the last reset.
    rd_miss(28'hA0, pat(28'hA0));
    rd_hit(28'hA0, pat(28'hA0));
    rd_miss(28'hC0, pat(28'hC0));
    rd_miss(28'hD0, pat(28'hD0));
    rd_hit(28'hC0, pat(28'hC0));
    rd_hit(28'hD0, pat(28'hD0));
    rd_hit(28'hA0, pat(28'hA0));
    rd_hit(28'hC0, pat(28'hC0));
`ifdef L2_PERF_CNT_EN
    chk("miss_cnt", 128'(miss_cnt), 128'd3);
    chk("hit_cnt", 128'(hit_cnt), 128'd5);
`endif

    repeat (5) @(negedge clk);
    chk("pending_expected", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l2_assoc.md
L2_ASSOC -- requirements
Module: l2_assoc

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, associativity (power of two, 2..8).
REQ-002 The block SHALL have parameter SETS, default 16, number of sets (power of two, 4..256).
REQ-003 The block SHALL have parameter LINE_W, default 128, line width in bits.
REQ-004 The block SHALL have parameter ADDR_W, default 28, line-address width; IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 addr  input  ADDR_W  L1 line address; index=addr[IDX_W-1:0], tag=addr[ADDR_W-1:IDX_W].
REQ-008 read  input  1  L1 read request, held until ready.
REQ-009 write  input  1  L1 write request, held until ready.
REQ-010 wdata  input  LINE_W  L1 write line.
REQ-011 rdata  output  LINE_W  read line, valid while ready=1.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 mem_read, mem_write  output  1 each  memory requests, held until mem_ready.
REQ-014 mem_addr  output  ADDR_W  memory line address.
REQ-015 mem_wdata  output  LINE_W  writeback line.
REQ-016 mem_rdata  input  LINE_W  fill line, valid with mem_ready.
REQ-017 mem_ready  input  1  memory completion, one-cycle pulse.

Function
REQ-018 The block SHALL be a WAYS-way set-associative, write-back, write-allocate cache with per-way valid, dirty, tag and age state.
REQ-019 The FSM SHALL have states IDLE, COMPARE, WRITEBACK, ALLOCATE; IDLE->COMPARE when read|write.
REQ-020 COMPARE hit: ready=1 on the next cycle, rdata=hit line on a read, return to IDLE; hit latency = 2 cycles from request sampling.
REQ-021 A write hit SHALL replace the line with wdata and set dirty=1.
REQ-022 On a miss, victim = lowest-indexed invalid way, else the way with age WAYS-1 (LRU).
REQ-023 A valid dirty victim SHALL go to WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held until mem_ready, then ALLOCATE.
REQ-024 Otherwise ALLOCATE: mem_read=1, mem_addr=addr, held until mem_ready; on mem_ready, fill the victim with mem_rdata, valid=1, dirty=0, tag=addr tag, then COMPARE.
REQ-025 mem_read and mem_write SHALL never be high together, and SHALL drop the cycle after mem_ready.
REQ-026 LRU: on a hit or fill of way w with age a, ways with age < a SHALL increment and w SHALL take age 0; ages within a set stay a permutation of 0..WAYS-1.
REQ-027 read and write high together SHALL be treated as a read.
REQ-028 A request dropped during a miss SHALL still complete the fill, then return to IDLE with no ready pulse.
REQ-029 ready SHALL not re-assert for a request already completed unless read/write is low for one cycle or addr changes.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, clear ready, mem_read and mem_write, and zero rdata, mem_addr and mem_wdata.
REQ-031 Reset SHALL clear all valid and dirty bits and set the age of way w to w in every set; a miss in flight is abandoned.

Configuration
REQ-032 With L2_PERF_CNT_EN defined, outputs hit_cnt[31:0] and miss_cnt[31:0] SHALL exist, reset to 0 and wrap at 2^32.
REQ-033 hit_cnt SHALL count first-evaluation COMPARE hits only (not post-fill compares); miss_cnt SHALL count misses.
REQ-034 Without L2_PERF_CNT_EN the counter ports and logic SHALL be absent and all other behaviour identical.

Verification
REQ-035 After reset, read addr=0x0000010 with mem_rdata=0xA5..A5 -> single mem_read at 0x0000010, then ready with rdata=0xA5..A5; immediate re-read -> ready 2 cycles after request, no mem access.
REQ-036 Write 0x0000023 (miss then hit), then fill 4 more tags into set 3 -> mem_write at 0x0000023 carrying the written data before the 5th fill's mem_read.
REQ-037 Tags 1,2,3,4 into set 0, re-read tag 1, then read tag 5 -> tag 2 evicted; tag 1 still hits.
REQ-038 Reset pulsed low while mem_read=1 -> mem_read=0 same cycle, state IDLE, prior hit address now misses.
REQ-039 read and write both high on hit line with wdata=0xFF..FF -> returns stored data, line unchanged, no dirty writeback on later eviction.
REQ-040 With L2_PERF_CNT_EN: 3 misses and 5 hits -> miss_cnt=3, hit_cnt=5.
